// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit majority voting, false-start rejection and a receive FIFO.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_ferr,
  output logic                 out_perr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic       PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`endif

  logic                 rx_m, rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           smp;
  logic                 vote;
  logic                 perr_bit;
  logic                 push;
  logic [EW-1:0]        push_entry;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc;
  logic                 perr_r;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Third vote sample is the live rx_s at the os_cnt = M+1 tick
  assign vote = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      smp     <= 2'b11;
`ifdef UART_RX_PARITY_EN
      par_acc <= 1'b0;
      perr_r  <= 1'b0;
`endif
    end else if (sample_tick) begin
      if (state == IDLE) begin
        if (!rx_s) begin
          os_cnt  <= '0;
          bit_cnt <= '0;
          state   <= START;
`ifdef UART_RX_PARITY_EN
          par_acc <= 1'b0;
`endif
        end
      end else begin
        os_cnt <= (os_cnt == CNT_LAST) ? '0 : os_cnt + CW'(1);
        if (os_cnt == CNT_LO)  smp[0] <= rx_s;
        if (os_cnt == CNT_MID) smp[1] <= rx_s;
        case (state)
          START: begin
            if (os_cnt == CNT_HI && vote) begin
              state  <= IDLE;
              os_cnt <= '0;
            end else if (os_cnt == CNT_LAST) begin
              state <= DATA;
            end
          end
          DATA: begin
            if (os_cnt == CNT_HI) begin
              shreg <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
              par_acc <= par_acc ^ vote;
`endif
            end
            if (os_cnt == CNT_LAST) begin
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (os_cnt == CNT_HI) perr_r <= vote ^ par_acc ^ PAR_ODD;
            if (os_cnt == CNT_LAST) state <= STOP;
          end
`endif
          STOP: begin
            // Leave mid-stop-bit so a back-to-back start edge is not missed
            if (os_cnt == CNT_HI) begin
              state  <= IDLE;
              os_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign perr_bit = perr_r;
`else
  assign perr_bit = 1'b0;
`endif

  assign push       = sample_tick && (state == STOP) && (os_cnt == CNT_HI);
  assign push_entry = {perr_bit, ~vote, shreg};

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wp, rp, rp_nx;
  logic          empty, full, pop, wr_en;
  logic [EW-1:0] head_d;

  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign out_valid = ~empty;
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign rp_nx     = rp + {{AW{1'b0}}, pop};
  // Bypass the write when the new head is the slot being written this cycle
  assign head_d    = (wr_en && (wp == rp_nx)) ? push_entry : mem[rp_nx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wp       <= '0;
      rp       <= '0;
      out_data <= '0;
      out_ferr <= 1'b0;
      out_perr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + (AW+1)'(1);
      rp <= rp_nx;
      {out_perr, out_ferr, out_data} <= head_d;
      if (push && full && !pop) overrun <= 1'b1;
      else if (ovr_clr)         overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an on-chip receive FIFO. It is the next-generation receive front end of the UART echo path. It runs entirely on the system clock, qualified by a one-cycle oversample enable, and uses mid-bit majority voting and false-start rejection. Each received frame is pushed into a DEPTH-entry FIFO together with per-frame error flags, and the FIFO drains through a valid/ready handshake.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: sample_tick pulses per bit period; even, at least 8.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PARITY_ODD, 0: parity sense, 1 = odd, 0 = even. Used only with UART_RX_PARITY_EN.
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low; clock clk.
- sample_tick  in  1  one-clk pulse at OVERSAMPLE × baud.
- rx  in  1  asynchronous serial line, idle high.
- out_data  out  DATA_BITS  FIFO head data, LSB received first.
- out_ferr  out  1  FIFO head framing error (stop bit sampled 0).
- out_perr  out  1  FIFO head parity error.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- overrun  out  1  sticky; set when a frame is dropped because the FIFO is full.
- ovr_clr  in  1  clears overrun.
- busy  out  1  receiver FSM not in IDLE.

## Operation
- rx passes through a 2-flop synchroniser (rx_s) before any use; rx_s resets to 1.
- os_cnt has width $clog2(OVERSAMPLE). It advances only on sample_tick and wraps from OVERSAMPLE-1 to 0.
- Each bit value is the majority of rx_s taken at os_cnt = M-1, M and M+1, where M = OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s == 0 on a sample_tick clears os_cnt to 0 and moves to START.
  - START: at the vote (os_cnt = M+1), a majority of 1 is a false start and returns to IDLE with nothing pushed. Otherwise the FSM goes to DATA at the os_cnt wrap.
  - DATA: bits are stored LSB first at each vote. After bit DATA_BITS-1 wraps, the FSM goes to PARITY if that state is compiled in, else to STOP.
  - PARITY: the voted bit is compared against the running XOR of the data bits, per PARITY_ODD.
  - STOP: at the vote the frame is complete. The FSM pushes {data, ferr = ~stop, perr} and returns to IDLE immediately, without waiting for the end of the stop bit, so back-to-back frames are supported.
- FIFO: read/write pointers are $clog2(DEPTH)+1 bits wide, with full/empty derived from the MSB compare. The head is registered to out_data/out_ferr/out_perr.
  - A pop occurs when out_valid && out_ready.
  - A push to a full FIFO is dropped and sets overrun. A push and a pop in the same cycle while full is accepted, with no overrun.
  - A push and a pop in the same cycle while empty writes the entry and leaves it valid, since the pop has no effect on an empty FIFO.
- overrun: when a set and ovr_clr occur in the same cycle, set wins.
- Reset clears the FSM to IDLE, both counters, the FIFO pointers and overrun. Reset outputs: out_valid = 0, busy = 0, overrun = 0, out_data = 0, out_ferr = 0, out_perr = 0. Reset mid-frame discards the partial frame.

## Timing
- rx to rx_s: 2 clk.
- Frame push occurs on the clk of the stop-bit vote tick, (1 + DATA_BITS + P) × OVERSAMPLE + M+1 ticks after the start edge is detected, where P = 1 with parity and 0 without.
- out_valid rises 1 clk after the push.
- out_data is stable while out_valid && !out_ready.
- Pop-to-next-head update: 1 clk.
- sample_tick with no gaps (every clk) is legal. All state changes are gated by sample_tick except the FIFO, overrun and reset logic.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists; out_perr reflects the parity check; PARITY_ODD is honoured.
- UART_RX_PARITY_EN undefined: no PARITY state; frames are start + DATA_BITS + stop; out_perr is tied 0; PARITY_ODD is ignored.

## Test plan
All scenarios use OVERSAMPLE=16, DATA_BITS=8, DEPTH=4 and a continuous sample_tick unless stated otherwise.
- Send 0xA5 with a valid stop bit, out_ready=1 -> one entry: out_data=0xA5, ferr=0, perr=0. busy falls at the stop vote.
- Drive a 4-tick low glitch on idle rx -> false start: FSM returns to IDLE, out_valid stays 0.
- Send 0x3C with stop bit = 0 -> entry out_data=0x3C, out_ferr=1. Then send 0x55 back-to-back -> a second clean entry.
- Hold out_ready=0 and send 0x01..0x05 -> 4 entries queued, 5th dropped, overrun=1. Pulse ovr_clr -> overrun=0. Drain -> 0x01..0x04 in order.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> out_perr=1. Resend with parity bit 1 -> out_perr=0.
- Assert n_rst=0 mid-data-bit, release, then send 0x9E -> only 0x9E appears, out_valid=0 in the reset cycle, overrun=0.
